wb_stage: RTL
=============

# wb_stage

Write-back stage of the five-stage pipeline: consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to the architectural register file. It also provides the two decode-stage read ports with same-cycle write-through bypass and keeps a retired-write counter. It sits directly after the MEM/WB register and feeds the ID stage.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register index width (2^REG_AW registers)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- wb_ctrl  in  2  from MEM/WB W field; bit1 = RegWrite, bit0 = MemtoReg; 2'b00 = bubble
- wb_rd_data  in  DATA_W  memory read data from MEM/WB
- wb_alu  in  DATA_W  ALU result / address from MEM/WB
- wb_wn  in  REG_AW  destination register number
- rs_addr  in  REG_AW  read port A index (ID stage)
- rt_addr  in  REG_AW  read port B index (ID stage)
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wb_data  out  DATA_W  selected write-back value (to forwarding unit)
- wb_we  out  1  effective write enable (to forwarding unit)
- retire_cnt  out  32  count of committed register writes

## Operation
- wb_data = wb_ctrl[0] ? wb_rd_data : wb_alu; combinational.
- wb_we = wb_ctrl[1] && (wb_wn != 0) && !rst; combinational.
- Register file: 2^REG_AW x DATA_W; r0 reads 0 always, never written.
- On rising clk with wb_we = 1: reg[wb_wn] <= wb_data.
- Read ports combinational: rs_data = (rs_addr == 0) ? 0 : (wb_we && rs_addr == wb_wn) ? wb_data : reg[rs_addr]; same for rt.
- Both ports may read the same index; both bypass.
- wb_ctrl = 2'b01 (MemtoReg without RegWrite): no write, no count; wb_data still driven.
- retire_cnt increments by 1 on each edge where wb_we = 1; wraps 0xFFFFFFFF -> 0.
- X on wb_ctrl is not tolerated; upstream drives 2'b00 on bubbles.

## Timing
- Write latency: one edge; value visible from reg array the cycle after, via bypass in the same cycle.
- Read latency: zero cycles (combinational).
- Reset (synchronous, priority over write): at the edge with rst = 1 all registers <= 0, retire_cnt <= 0; a write presented in that cycle is dropped and not counted.
- During rst = 1: wb_we = 0, so no bypass; rs_data/rt_data show current array contents (0 after first reset edge).
- Reset mid-stream: first write accepted on the first edge with rst = 0.
- Outputs after reset: rs_data = rt_data = 0, retire_cnt = 0, wb_we = 0, wb_data follows inputs.

## Structure
- Shared pipeline package: W_REGWRITE = 1, W_MEMTOREG = 0 bit indices, REG_ZERO = 0, DATA_W/REG_AW defaults; MEM/WB register and this block use the same constants.
- One sub-module: regfile_2r1w (storage, r0 hardwiring, bypass read ports, synchronous reset clear). wb_stage holds the mux, wb_we logic and retire counter.

## Test plan
- Reset then read: rst high one edge, read r1/r31 -> 0, retire_cnt = 0.
- ALU write: wb_ctrl=2'b10, wb_alu=0x12345678, wb_wn=5, rs_addr=5 same cycle -> rs_data=0x12345678 (bypass); next cycle with wb_ctrl=00 -> still 0x12345678, retire_cnt=1.
- Load write: wb_ctrl=2'b11, wb_rd_data=0xDEADBEEF, wb_alu=0x1000, wb_wn=7 -> wb_data=0xDEADBEEF, r7=0xDEADBEEF after edge.
- r0 protection: wb_ctrl=2'b10, wb_wn=0, wb_alu=0xFFFFFFFF -> wb_we=0, rs_addr=0 reads 0, retire_cnt unchanged.
- Reset collides with write: rst=1 and wb_ctrl=2'b10, wb_wn=3, wb_alu=0x55 same edge -> r3=0, retire_cnt=0.
- Counter wrap: preload retire_cnt to 0xFFFFFFFF via forced 2^32-1 writes (or backdoor), one more valid write -> retire_cnt=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared pipeline constants for the MEM/WB register and the write-back stage.
// Also holds the write-back value select used by both.
package wb_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int CNT_W    = 32;

  // Bit positions inside the 2-bit W control field carried by MEM/WB.
  localparam int W_REGWRITE = 1;
  localparam int W_MEMTOREG = 0;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef logic [1:0]        wb_ctrl_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  function automatic data_t wb_select(input wb_ctrl_t ctrl,
                                      input data_t    rd_data,
                                      input data_t    alu);
    return ctrl[W_MEMTOREG] ? rd_data : alu;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between MEM/WB + ID (master side) and the write-back stage (slave side).
// There is no valid/ready pair: a slot commits when wb_ctrl[W_REGWRITE] is set
// and wb_wn is non-zero, bubbles arrive as 2'b00, and this stage never stalls.
interface wb_stage_if;
  import wb_stage_pkg::*;

  wb_ctrl_t wb_ctrl;
  data_t    wb_rd_data;
  data_t    wb_alu;
  reg_idx_t wb_wn;
  reg_idx_t rs_addr;
  reg_idx_t rt_addr;
  data_t    rs_data;
  data_t    rt_data;
  data_t    wb_data;
  logic     wb_we;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output wb_ctrl, wb_rd_data, wb_alu, wb_wn, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, retire_cnt
  );

  modport slave (
    input  wb_ctrl, wb_rd_data, wb_alu, wb_wn, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, retire_cnt
  );

endinterface

// File: rtl/wb_stage_regfile_2r1w.sv
// Architectural register file: two combinational read ports with same-cycle
// write-through bypass, one write port, r0 hardwired to zero, sync clear.
module regfile_2r1w
  import wb_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  reg_idx_t waddr,
  input  data_t    wdata,
  input  reg_idx_t ra_addr,
  input  reg_idx_t rb_addr,
  output data_t    ra_data,
  output data_t    rb_data
);

  data_t regs [NUM_REGS];

  // Reset wins over a write presented in the same cycle; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == REG_ZERO) begin
      ra_data = '0;
    end else if (we && (ra_addr == waddr)) begin
      ra_data = wdata;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == REG_ZERO) begin
      rb_data = '0;
    end else if (we && (rb_addr == waddr)) begin
      rb_data = wdata;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, serves the two ID-stage read ports and counts retired writes.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  wb
);

  data_t            sel_data;
  logic             eff_we;
  data_t            ra_data;
  data_t            rb_data;
  logic [CNT_W-1:0] retire_cnt_q;

  assign sel_data = wb_select(wb.wb_ctrl, wb.wb_rd_data, wb.wb_alu);

  // rst gates the enable so neither bypass nor the forwarding unit sees a write
  // that the array is about to drop.
  assign eff_we = wb.wb_ctrl[W_REGWRITE] && (wb.wb_wn != REG_ZERO) && !rst;

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (eff_we),
    .waddr   (wb.wb_wn),
    .wdata   (sel_data),
    .ra_addr (wb.rs_addr),
    .rb_addr (wb.rt_addr),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (eff_we) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign wb.wb_data    = sel_data;
  assign wb.wb_we      = eff_we;
  assign wb.rs_data    = ra_data;
  assign wb.rt_data    = rb_data;
  assign wb.retire_cnt = retire_cnt_q;

endmodule
